uart_tx: RTL and testbench

Serial UART transmitter that takes parallel words over a valid/ready handshake and drives an asynchronous line with start bit, LSB-first data, optional parity and 1–3 stop bits. It is the transmit-side partner of the team's UART receiver and pairs with the TX FIFO in the UART-with-FIFO subsystem. The FIFO read side drives `valid`/`data_in`, and `tx` goes to the pad. The frame format parameters must match the receiver at the far end.

---
 rtl/uart_tx.sv | 179 +++++++++++++++++
 tb/tb_uart_tx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word in, start + LSB-first data + optional parity + stop bits out.
// Optional feature: define UART_TX_HOLD_EN for a one-entry holding register that chains frames.
module uart_tx #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned SYS_CLK     = 100_000_000,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned HAS_PARITY  = 0,
  parameter int unsigned PARITY_EVEN = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  output logic                 ready,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned N     = SYS_CLK / BAUD_RATE;
  localparam int unsigned CNT_W = (N < 2) ? 1 : $clog2(N);
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

  if (N < 2) begin : g_bad_baud
    $error("uart_tx: SYS_CLK/BAUD_RATE must be at least 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 3) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1..3");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx: DATA_BITS must be 5..9");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;

  logic                 strobe_c;
  logic                 last_stop_c;
  logic                 accept_c;
  logic                 start_frame_c;
  logic [DATA_BITS-1:0] start_word_c;
  logic                 start_par_c;

  assign strobe_c    = (cnt == CNT_W'(N - 1));
  assign last_stop_c = (state == S_STOP) && strobe_c && (bit_cnt == BIT_W'(STOP_BITS - 1));
  assign accept_c    = valid && ready;
  assign start_par_c = (PARITY_EVEN != 0) ? (^start_word_c) : (~^start_word_c);

`ifdef UART_TX_HOLD_EN
  logic                 hold_full;
  logic [DATA_BITS-1:0] hold_data;
  logic                 direct_c;
  logic                 hold_full_next_c;

  // A held word always wins over the input; a new word goes straight to the shifter only when idle and empty.
  always_comb begin
    direct_c         = (state == S_IDLE) && !hold_full;
    start_frame_c    = (hold_full && ((state == S_IDLE) || last_stop_c)) || (accept_c && direct_c);
    start_word_c     = hold_full ? hold_data : data_in;
    hold_full_next_c = hold_full;
    if (start_frame_c && hold_full) hold_full_next_c = 1'b0;
    if (accept_c && !direct_c)      hold_full_next_c = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      ready     <= 1'b0;
    end else begin
      hold_full <= hold_full_next_c;
      if (accept_c && !direct_c) hold_data <= data_in;
      ready <= !hold_full_next_c;
    end
  end
`else
  always_comb begin
    start_frame_c = accept_c && (state == S_IDLE);
    start_word_c  = data_in;
  end

  // Ready only while the FSM sits (or is about to sit) in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready <= 1'b0;
    end else begin
      ready <= !start_frame_c && ((state == S_IDLE) || last_stop_c);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      cnt <= ((state == S_IDLE) || strobe_c) ? '0 : cnt + CNT_W'(1);
      if (start_frame_c) begin
        state   <= S_START;
        cnt     <= '0;
        bit_cnt <= '0;
        shift   <= start_word_c;
        par_bit <= start_par_c;
        tx      <= 1'b0;
        busy    <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            tx   <= 1'b1;
            busy <= 1'b0;
          end
          S_START: begin
            if (strobe_c) begin
              state <= S_DATA;
              tx    <= shift[0];
            end
          end
          S_DATA: begin
            if (strobe_c) begin
              if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                bit_cnt <= '0;
                if (HAS_PARITY != 0) begin
                  state <= S_PARITY;
                  tx    <= par_bit;
                end else begin
                  state <= S_STOP;
                  tx    <= 1'b1;
                end
              end else begin
                shift   <= shift >> 1;
                tx      <= shift[1];
                bit_cnt <= bit_cnt + BIT_W'(1);
              end
            end
          end
          S_PARITY: begin
            if (strobe_c) begin
              state <= S_STOP;
              tx    <= 1'b1;
            end
          end
          S_STOP: begin
            if (strobe_c) begin
              if (last_stop_c) begin
                state   <= S_IDLE;
                bit_cnt <= '0;
                busy    <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
              end
            end
          end
          default: begin
            state <= S_IDLE;
            tx    <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: default 8N1, parity even/odd, two stop bits, mid-frame reset.
`timescale 1ns/1ps
module tb_uart_tx;

`ifdef UART_TX_HOLD_EN
  localparam bit RDY_IN_FRAME = 1'b1;
`else
  localparam bit RDY_IN_FRAME = 1'b0;
`endif
  localparam int N_DEF = 868;
  localparam int N_SML = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] valid_v = '0;
  logic [7:0] data = '0;
  logic [3:0] ready_v, tx_v, busy_v;
  logic       tx_s, busy_s, ready_s;
  int         sel = 0;
  int         total = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  uart_tx u_def (
    .clk(clk), .reset(reset), .valid(valid_v[0]), .ready(ready_v[0]),
    .data_in(data), .tx(tx_v[0]), .busy(busy_v[0])
  );
  uart_tx #(.SYS_CLK(400), .BAUD_RATE(100), .HAS_PARITY(1), .PARITY_EVEN(1)) u_pe (
    .clk(clk), .reset(reset), .valid(valid_v[1]), .ready(ready_v[1]),
    .data_in(data), .tx(tx_v[1]), .busy(busy_v[1])
  );
  uart_tx #(.SYS_CLK(400), .BAUD_RATE(100), .HAS_PARITY(1), .PARITY_EVEN(0)) u_po (
    .clk(clk), .reset(reset), .valid(valid_v[2]), .ready(ready_v[2]),
    .data_in(data), .tx(tx_v[2]), .busy(busy_v[2])
  );
  uart_tx #(.SYS_CLK(400), .BAUD_RATE(100), .STOP_BITS(2)) u_s2 (
    .clk(clk), .reset(reset), .valid(valid_v[3]), .ready(ready_v[3]),
    .data_in(data), .tx(tx_v[3]), .busy(busy_v[3])
  );

  always_comb begin
    tx_s    = tx_v[sel[1:0]];
    busy_s  = busy_v[sel[1:0]];
    ready_s = ready_v[sel[1:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a word on the selected instance at a falling edge; the next rising edge accepts it.
  task automatic send(input int s, input logic [7:0] w, input string tag);
    @(negedge clk);
    sel = s;
    #1;
    chk({tag, ".ready_before"}, 32'(ready_s), 32'd1);
    data = w;
    valid_v[s] = 1'b1;
  endtask

  // Cycle-by-cycle check of one frame after the accepting edge, then the following idle cycle.
  task automatic check_frame(input int n, input int pbit_en, input logic pbit, input int stops,
                             input logic [7:0] word, input bit keep_valid, input string tag);
    int   f, b, bad_tx, bad_busy, bad_rdy, first;
    logic exp_tx, first_obs, first_exp;
    f = n * (1 + 8 + pbit_en + stops);
    bad_tx = 0; bad_busy = 0; bad_rdy = 0; first = 0;
    first_obs = 1'b0; first_exp = 1'b0;
    for (int i = 0; i < f; i++) begin
      @(negedge clk);
      if (i == 0 && !keep_valid) valid_v[sel] = 1'b0;
      b = i / n;
      if (b == 0)                        exp_tx = 1'b0;
      else if (b <= 8)                   exp_tx = word[b-1];
      else if (pbit_en != 0 && b == 9)   exp_tx = pbit;
      else                               exp_tx = 1'b1;
      if (tx_s !== exp_tx) begin
        if (bad_tx == 0) begin
          first = i + 1; first_obs = tx_s; first_exp = exp_tx;
        end
        bad_tx++;
      end
      if (busy_s !== 1'b1) bad_busy++;
      if (ready_s !== RDY_IN_FRAME) bad_rdy++;
    end
    total++;
    assert (bad_tx == 0) else begin
      fails++;
      $error("FAIL %s.tx %0d bad cycles, first at cycle %0d observed=%b expected=%b",
             tag, bad_tx, first, first_obs, first_exp);
    end
    chk({tag, ".busy_bad_cycles"}, 32'(bad_busy), 32'd0);
    chk({tag, ".ready_bad_cycles"}, 32'(bad_rdy), 32'd0);
    @(negedge clk);
    chk({tag, ".idle_tx"}, 32'(tx_s), 32'd1);
    chk({tag, ".idle_busy"}, 32'(busy_s), 32'd0);
    chk({tag, ".idle_ready"}, 32'(ready_s), 32'd1);
  endtask

`ifdef UART_TX_HOLD_EN
  // Three chained words with valid held high; frames must abut with no idle cycle.
  task automatic hold_stream();
    int         f, c, k, b;
    int         bad_tx, bad_busy, bad_rdy;
    logic [7:0] words [3];
    logic       exp_tx, exp_busy, exp_rdy;
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    f = N_DEF * 10;
    bad_tx = 0; bad_busy = 0; bad_rdy = 0;
    send(0, 8'h11, "hold");
    for (int i = 0; i <= 3 * f; i++) begin
      @(negedge clk);
      c = i + 1;
      if (c == 1) chk("hold.ready_c1", 32'(ready_s), 32'd1);
      if (c == 2) chk("hold.ready_c2", 32'(ready_s), 32'd0);
      if (c == 1) data = 8'h22;
      if (c == 2) data = 8'h33;
      if (c == f + 2) valid_v[0] = 1'b0;
      if (c <= 3 * f) begin
        k = (c - 1) / f;
        b = ((c - 1) % f) / N_DEF;
        if (b == 0)       exp_tx = 1'b0;
        else if (b <= 8)  exp_tx = words[k][b-1];
        else              exp_tx = 1'b1;
        exp_busy = 1'b1;
      end else begin
        exp_tx = 1'b1;
        exp_busy = 1'b0;
      end
      exp_rdy = (c == 1) || (c == f + 1) || (c >= 2 * f + 1);
      if (tx_s !== exp_tx) bad_tx++;
      if (busy_s !== exp_busy) bad_busy++;
      if (ready_s !== exp_rdy) bad_rdy++;
    end
    chk("hold.tx_bad_cycles", 32'(bad_tx), 32'd0);
    chk("hold.busy_bad_cycles", 32'(bad_busy), 32'd0);
    chk("hold.ready_bad_cycles", 32'(bad_rdy), 32'd0);
  endtask
`endif

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", total - fails, total);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for three cycles with valid low.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst.tx", 32'(tx_s), 32'd1);
      chk("rst.busy", 32'(busy_s), 32'd0);
      chk("rst.ready", 32'(ready_s), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst.ready", 32'(ready_s), 32'd1);
    chk("post_rst.tx", 32'(tx_s), 32'd1);
    chk("post_rst.busy", 32'(busy_s), 32'd0);

    // 0xA5 on defaults: line 0,1,0,1,0,0,1,0,1,1.
    send(0, 8'hA5, "a5");
    check_frame(N_DEF, 0, 1'b0, 1, 8'hA5, 1'b0, "a5");

    // 0x07 has three ones: even parity bit 1, odd parity bit 0.
    send(1, 8'h07, "par_even");
    check_frame(N_SML, 1, 1'b1, 1, 8'h07, 1'b0, "par_even");
    send(2, 8'h07, "par_odd");
    check_frame(N_SML, 1, 1'b0, 1, 8'h07, 1'b0, "par_odd");

`ifndef UART_TX_HOLD_EN
    // Two stop bits with valid held: second start one idle cycle after the stop bits.
    send(3, 8'h5A, "stop2");
    check_frame(N_SML, 0, 1'b0, 2, 8'h5A, 1'b1, "stop2_f1");
    check_frame(N_SML, 0, 1'b0, 2, 8'h5A, 1'b0, "stop2_f2");
`endif

    // Reset during data bit 3 (a zero for 0xA5), then a clean frame.
    send(0, 8'hA5, "midrst");
    for (int j = 0; j < 4 * N_DEF + N_DEF / 2; j++) begin
      @(negedge clk);
      if (j == 0) valid_v[0] = 1'b0;
    end
    chk("midrst.bit3_tx", 32'(tx_s), 32'd0);
    chk("midrst.bit3_busy", 32'(busy_s), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst.tx", 32'(tx_s), 32'd1);
    chk("midrst.busy", 32'(busy_s), 32'd0);
    chk("midrst.ready", 32'(ready_s), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst.ready_after", 32'(ready_s), 32'd1);
    send(0, 8'h3C, "after_rst");
    check_frame(N_DEF, 0, 1'b0, 1, 8'h3C, 1'b0, "after_rst");

`ifdef UART_TX_HOLD_EN
    hold_stream();
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
